// File: rtl/fetch_controller.sv
// Purpose : instruction fetch controller; PC drives a combinational imem, fetched
//           words are queued in a small buffer and presented to decode.
// Latency : a word fetched in cycle N reaches the buffer head in cycle N+1 (no bypass).
// Backpr. : fetch stalls (PC held) while the buffer is full and decode does not pop.
//
// Ports
//   clk, reset      single clock, synchronous active-high reset
//   imem_addr       word index presented to instruction memory (the PC register)
//   imem_instr      instruction word returned for imem_addr in the same cycle
//   redirect_valid  one-cycle branch/jump pulse; flushes the buffer
//   redirect_addr   target word index; out-of-range targets restart at 0
//   inst_valid      buffer head holds an instruction
//   inst_ready      decode takes the head this cycle
//   inst_data       instruction at the buffer head
//   inst_pc         word index the head instruction was fetched from
//   halted          controller is in HALT
//
// Build option: define FETCH_HALT_ON_ZERO_EN to stop fetching on an all-zero
// instruction word (enters HALT). Without it, zero words are ordinary
// instructions and halted is tied low.
//
// FIFO_DEPTH must be a power of two >= 2: the pointers wrap naturally.

module fetch_controller #(
  parameter int IMEM_DEPTH = 1280,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        halted
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [31:0]      PC_LAST  = 32'(IMEM_DEPTH - 1);
  localparam logic [31:0]      PC_LIMIT = 32'(IMEM_DEPTH);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [31:0]      pc;
  logic [0:0]       state;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  fetch_entry_t     entries [FIFO_DEPTH];

  // --------------------------------------------------------------------------
  // Control
  // --------------------------------------------------------------------------
  logic full;
  logic pop;
  logic push;
  logic running;
  logic zero_word;
  logic halt_now;
  logic [31:0] pc_inc;
  logic [31:0] redirect_target;

  assign full       = (count == CNT_FULL);
  assign inst_valid = (count != '0);
  // Pops come only from the registered head; a word fetched this cycle can
  // never be handed to decode in the same cycle.
  assign pop        = inst_valid && inst_ready;
  assign running    = (state != ST_HALT);

`ifdef FETCH_HALT_ON_ZERO_EN
  assign zero_word  = (imem_instr == 32'h0);
`else
  assign zero_word  = 1'b0;
`endif

  // A full buffer still accepts a push when the head leaves in the same cycle,
  // so a continuously ready consumer sees one instruction per cycle.
  assign push     = running && !redirect_valid && !zero_word && (!full || pop);
  // A zero word halts regardless of buffer space; PC stays on it so a later
  // redirect is the only way out.
  assign halt_now = running && !redirect_valid && zero_word;

  assign pc_inc          = (pc == PC_LAST) ? 32'h0 : (pc + 32'd1);
  assign redirect_target = (redirect_addr >= PC_LIMIT) ? 32'h0 : redirect_addr;

  // --------------------------------------------------------------------------
  // Sequential update
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      pc     <= 32'h0;
      state  <= ST_RUN;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      // Storage is cleared so the head reads as zero straight out of reset.
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else if (redirect_valid) begin
      // Flush by collapsing the write pointer onto the read pointer; the head
      // slot keeps its old contents, which the consumer ignores while empty.
      pc     <= redirect_target;
      state  <= ST_RUN;
      count  <= '0;
      wr_ptr <= rd_ptr;
    end else begin
      if (push) begin
        entries[wr_ptr] <= '{instr: imem_instr, pc: pc};
        wr_ptr          <= wr_ptr + PTR_ONE;
        pc              <= pc_inc;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (halt_now) begin
        state <= ST_HALT;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign imem_addr = pc;
  assign inst_data = entries[rd_ptr].instr;
  assign inst_pc   = entries[rd_ptr].pc;

`ifdef FETCH_HALT_ON_ZERO_EN
  assign halted = (state == ST_HALT);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Purpose : self-checking bench for fetch_controller with a scoreboard of
//           expected deliveries and directed checks of fetch state.
// Ports   : none (top-level bench); drives the DUT with a combinational memory model.

module tb_fetch_controller;

  logic        clk;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        halted;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  fetch_controller #(
    .IMEM_DEPTH(1280),
    .FIFO_DEPTH(2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .halted         (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: word 12 is zero, every other word is nonzero and unique.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'd12) return 32'h0;
    return 32'hC0DE_0000 ^ a;
  endfunction

  assign imem_instr = mem_word(imem_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic expect_pc(input logic [31:0] a);
    exp_q.push_back('{pc: a, data: mem_word(a)});
  endtask

  task automatic check_drained(input string name);
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: every accepted head is compared against the next expected entry.
  // Cycles with reset or redirect are skipped because those take priority over
  // the handshake.
  always @(negedge clk) begin
    if (!reset && !redirect_valid && inst_valid && inst_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_delivery actual_pc=%0d actual_data=%h required=none",
                 inst_pc, inst_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (inst_pc !== mon_e.pc || inst_data !== mon_e.data) begin
          failures++;
          $display("FAIL delivery actual pc=%0d data=%h required pc=%0d data=%h",
                   inst_pc, inst_data, mon_e.pc, mon_e.data);
        end
      end
    end
  end

  initial begin
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_addr  = 32'h0;
    inst_ready     = 1'b1;

    // ---- Straight-line fetch from reset, consumer always ready ----
    tick();
    tick();
    check("reset_valid", 32'(inst_valid), 32'd0);
    check("reset_data",  inst_data, 32'h0);
    check("reset_pc",    inst_pc,   32'h0);
    check("reset_halt",  32'(halted), 32'd0);
    check("reset_addr",  imem_addr, 32'h0);
    for (int i = 0; i < 12; i++) expect_pc(32'(i));
`ifndef FETCH_HALT_ON_ZERO_EN
    expect_pc(32'd12);
`endif
    reset = 1'b0;                     // cycle 1
    tick();                           // cycle 2
    check("first_latency_valid", 32'(inst_valid), 32'd1);
    check("first_latency_pc",    inst_pc, 32'd0);
    for (int i = 0; i < 13; i++) tick();   // cycle 15
    inst_ready = 1'b0;
    check_drained("drain_linear");
`ifdef FETCH_HALT_ON_ZERO_EN
    check("zero_halted",     32'(halted), 32'd1);
    check("zero_pc_held",    imem_addr, 32'd12);
    check("zero_not_pushed", 32'(inst_valid), 32'd0);
`else
    check("no_halt_default", 32'(halted), 32'd0);
`endif

    // ---- Backpressure from reset ----
    reset = 1'b1;
    tick();
    reset = 1'b0;                     // cycle 1, ready low
    expect_pc(32'd0);
    expect_pc(32'd1);
    expect_pc(32'd2);
    for (int i = 0; i < 4; i++) tick();    // cycle 5
    check("stall_addr", imem_addr, 32'd2);
    check("stall_head", inst_pc, 32'd0);
    tick();                           // cycle 6
    inst_ready = 1'b1;
    tick();                           // cycle 7
    check("no_gap_c7", 32'(inst_valid), 32'd1);
    tick();                           // cycle 8
    check("no_gap_c8", 32'(inst_valid), 32'd1);
    tick();                           // cycle 9
    inst_ready = 1'b0;
    check_drained("drain_stall");
    check("full_pushpop_addr", imem_addr, 32'd5);
    check("pre_redirect_head", inst_pc, 32'd3);

    // ---- Redirect flushes PCs 3,4 ----
    redirect_valid = 1'b1;
    redirect_addr  = 32'd9;
    inst_ready     = 1'b1;
    expect_pc(32'd9);
    expect_pc(32'd10);
    tick();                           // cycle 10
    redirect_valid = 1'b0;
    check("flush_valid", 32'(inst_valid), 32'd0);
    check("flush_addr",  imem_addr, 32'd9);
    tick();
    tick();
    tick();                           // cycle 13
    inst_ready = 1'b0;
    check_drained("drain_redirect");
    tick();
    tick();                           // cycle 15
`ifdef FETCH_HALT_ON_ZERO_EN
    check("halt_after_redirect", 32'(halted), 32'd1);
    check("halt_pc_held",        imem_addr, 32'd12);
`else
    check("full_after_redirect", imem_addr, 32'd13);
`endif

    // ---- Out-of-range redirect (also leaves HALT) ----
    redirect_valid = 1'b1;
    redirect_addr  = 32'd5000;
    inst_ready     = 1'b1;
    expect_pc(32'd0);
    expect_pc(32'd1);
    tick();
    redirect_valid = 1'b0;
    check("oor_addr",   imem_addr, 32'd0);
    check("oor_valid",  32'(inst_valid), 32'd0);
    check("oor_halted", 32'(halted), 32'd0);
    tick();
    tick();
    tick();
    inst_ready = 1'b0;
    check_drained("drain_oor");

    // ---- Wrap at the top of memory ----
    redirect_valid = 1'b1;
    redirect_addr  = 32'd1278;
    inst_ready     = 1'b1;
    expect_pc(32'd1278);
    expect_pc(32'd1279);
    expect_pc(32'd0);
    expect_pc(32'd1);
    tick();
    redirect_valid = 1'b0;
    check("wrap_target", imem_addr, 32'd1278);
    for (int i = 0; i < 5; i++) tick();
    inst_ready = 1'b0;
    check_drained("drain_wrap");
    check("wrap_addr_after", imem_addr, 32'd3);

    // ---- Reset beats a redirect while the buffer is full ----
    tick();
    tick();
    check("prereset_full_valid", 32'(inst_valid), 32'd1);
    check("prereset_full_addr",  imem_addr, 32'd4);
    reset          = 1'b1;
    redirect_valid = 1'b1;
    redirect_addr  = 32'd7;
    inst_ready     = 1'b1;
    tick();
    reset          = 1'b0;
    redirect_valid = 1'b0;
    check("midreset_valid",  32'(inst_valid), 32'd0);
    check("midreset_addr",   imem_addr, 32'd0);
    check("midreset_halted", 32'(halted), 32'd0);
    check("midreset_data",   inst_data, 32'h0);
    check("midreset_pc",     inst_pc, 32'h0);
    expect_pc(32'd0);
    expect_pc(32'd1);
    expect_pc(32'd2);
    tick();
    tick();
    tick();
    tick();
    inst_ready = 1'b0;
    check_drained("drain_restart");

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
